// File: rtl/shift_left_seq_if.sv
// Request/result bundle for the sequential left shifter.
// The requester drives start/a/b; the shifter returns out/busy/done.
interface shift_left_seq_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] out;
  logic         busy;
  logic         done;

  modport master (output start, a, b, input out, busy, done);
  modport slave  (input start, a, b, output out, busy, done);
endinterface

// File: rtl/shift_left_seq.sv
// Multi-cycle log-stage left shifter: one power-of-two stage per clock, done pulse on completion.
// Define SHL_ROTATE_EN to rotate left by (b mod N) instead of shifting with zero fill.
module shift_left_seq #(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst,
  shift_left_seq_if.slave   bus
);
  localparam int L = $clog2(N);
  localparam logic [L-1:0] LAST_STAGE = L[L-1:0] - 1'b1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t       state_reg, state_next;
  logic [N-1:0] acc_reg, acc_next;
  logic [L-1:0] amt_reg, amt_next;
  logic [L-1:0] stage_reg, stage_next;
  logic [N-1:0] out_reg, out_next;

  // Candidate value for every stage; the active stage picks one below.
  logic [N-1:0] stage_val [L];
  logic [N-1:0] stage_sel;
  logic [N-1:0] acc_step;

  generate
    for (genvar gi = 0; gi < L; gi++) begin : g_stage
`ifdef SHL_ROTATE_EN
      assign stage_val[gi] = {acc_reg[N-1-(2**gi):0], acc_reg[N-1:N-(2**gi)]};
`else
      assign stage_val[gi] = acc_reg << (2**gi);
`endif
    end
  endgenerate

  always_comb begin
    stage_sel = acc_reg;
    for (int i = 0; i < L; i++) begin
      if (stage_reg == i[L-1:0]) stage_sel = stage_val[i];
    end
    acc_step = amt_reg[stage_reg] ? stage_sel : acc_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      amt_reg   <= '0;
      stage_reg <= '0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      amt_reg   <= amt_next;
      stage_reg <= stage_next;
      out_reg   <= out_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    amt_next   = amt_reg;
    stage_next = stage_reg;
    out_next   = out_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          acc_next   = bus.a;
          amt_next   = bus.b[L-1:0];
          stage_next = '0;
`ifdef SHL_ROTATE_EN
          state_next = SHIFT;
`else
          // Any amount >= N clears every bit, so skip the stages entirely.
          if (|bus.b[N-1:L]) begin
            out_next   = '0;
            state_next = DONE;
          end else begin
            state_next = SHIFT;
          end
`endif
        end
      end
      SHIFT: begin
        acc_next   = acc_step;
        stage_next = stage_reg + 1'b1;
        if (stage_reg == LAST_STAGE) begin
          out_next   = acc_step;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.out  = out_reg;
  assign bus.busy = (state_reg != IDLE);
  assign bus.done = (state_reg == DONE);
endmodule

// File: doc/shift_left_seq.md
Name: shift_left_seq

Overview:
- Multi-cycle left shifter for the ALU datapath, run as a sequential log-stage barrel.
- Latches operand `a` and shift amount `b` on a start request.
- Applies one power-of-two shift stage per clock, controlled by one bit of `b` per stage.
- Reports the result with a one-cycle `done` pulse. It is the left-direction counterpart of the combinational arithmetic right shifter, and is used where area matters more than latency.

Parameters:
- N, 8, data width; must be a power of two, N >= 4. Let L = $clog2(N).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  N  operand to shift.
- b  input  N  shift amount (unsigned, full width).
- out  output  N  result register; holds the last result.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse; `out` is valid from this cycle on.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE, out=0, busy=0, done=0.
  - Internal acc, amt and stage counter cleared.
  - Any in-flight operation is abandoned with no `done`.
- States: IDLE, SHIFT, DONE. busy = (state != IDLE); done = (state == DONE).
- IDLE:
  - start=0: stay in IDLE.
  - start=1: acc<=a, amt<=b, stage<=0.
  - If any of b[N-1:L] is 1 (amount >= N) and SHL_ROTATE_EN is undefined: out<=0 and go to DONE. `done` rises at t+1 for a start sampled at edge t.
  - Otherwise go to SHIFT.
- SHIFT, per clock:
  - If amt[stage]=1: acc <= acc << 2^stage, zero-fill; bits shifted past MSB are discarded.
  - stage<=stage+1.
  - When stage==L-1: out<= next acc value and go to DONE.
- Latency: `done` at t+L+1 for a start sampled at edge t (t+4 for N=8).
  - Every stage is visited even when its amt bit is 0; b=0 still takes L+1 cycles.
- DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally.
  - A `start` during DONE is ignored.
  - A new request is accepted from the IDLE cycle that follows.
- `start` while busy: ignored; latched operands are unaffected by changes on `a`/`b`.
- `out` changes only on entry to DONE or on reset. Between operations it holds its value.
- Back-to-back: the minimum start-to-start spacing is L+2 cycles.
- Width rules:
  - All arithmetic is N bits; no sign handling; no carry output.
  - Only b[L-1:0] drives the stages. The upper bits of `b` only trigger the zero result.

Optional Feature:
- Macro: SHL_ROTATE_EN.
- Defined:
  - The block performs rotate-left by (b mod N).
  - Each stage does acc <= {acc[N-1-2^stage:0], acc[N-1:N-2^stage]}.
  - b[N-1:L] is ignored; the zero-result shortcut is removed, so every operation takes L+1 cycles.
- Undefined: logical shift-left with zero fill, plus the amount >= N shortcut described above.

Test Plan:
- Reset, then a=8'h8D, b=3, start pulse at edge t -> busy=1 from t; done=1 and out=8'h68 at t+4; busy=0 at t+5. With SHL_ROTATE_EN: out=8'h6C.
- a=8'h8D, b=0 -> out=8'h8D, with done at t+4; confirms all stages are walked.
- a=8'h01, b=7 -> out=8'h80 at t+4.
- a=8'hFF, b=9:
  - Without macro: done at t+1 with out=8'h00, then IDLE at t+2.
  - With SHL_ROTATE_EN: done at t+4, out=8'hFF.
  - Repeat with a=8'h81, b=9 under SHL_ROTATE_EN -> out=8'h03.
- Start a=8'h03, b=2. At t+1 pulse start again with a=8'hFF, b=1 and change a/b -> the second start is ignored; out=8'h0C at t+4 and only one done pulse occurs.
- Start a=8'h11, b=4 after a prior result out=8'h0C. Assert rst asynchronously at t+2 (between edges) -> out, busy and done go to 0 immediately; no done follows. After release, a new start a=8'h11, b=4 gives out=8'h10 at its t+4.
